// File: rtl/seg7_temp_display.sv
// Four-digit multiplexed 7-segment driver for packed sign/tens/units/tenths temperature.
// Define SEG7_LZB_EN to blank a zero tens digit (leading-zero blanking).
module seg7_temp_display #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned BLANK_CYC   = 20
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        En,
    input  logic        Load,
    input  logic [15:0] temp,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  An
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef struct packed {
        logic [3:0] sign;
        logic [3:0] tens;
        logic [3:0] units;
        logic [3:0] tenths;
    } temp_t;

    temp_t            shadow_q, shadow_d;
    temp_t            disp_q,   disp_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       idx_q,    idx_d;
    logic [6:0]       seg_q,    seg_d;
    logic             dp_q,     dp_d;
    logic [3:0]       an_q,     an_d;

    // Active-low BCD decode; out-of-range nibbles show an 'E' glyph.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h06;
        endcase
        return s;
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        an_d     = 4'hF;

        if (Load) begin
            shadow_d = temp_t'(temp);
        end

        // Scan advance; the display copy only changes at the frame boundary.
        if (!En) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                disp_d = Load ? temp_t'(temp) : shadow_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (En && (cnt_q >= BLANK_END)) begin
            an_d = ~(4'b0001 << idx_q);
            case (idx_q)
                2'd0: seg_d = seg_decode(disp_q.tenths);
                2'd1: begin
                    seg_d = seg_decode(disp_q.units);
                    dp_d  = 1'b0;
                end
                2'd2: begin
`ifdef SEG7_LZB_EN
                    seg_d = (disp_q.tens == 4'd0) ? SEG_OFF : seg_decode(disp_q.tens);
`else
                    seg_d = seg_decode(disp_q.tens);
`endif
                end
                default: seg_d = (disp_q.sign != 4'd0) ? SEG_MINUS : SEG_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            shadow_q <= '0;
            disp_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            an_q     <= 4'hF;
        end else begin
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign Seg = seg_q;
    assign Dp  = dp_q;
    assign An  = an_q;

endmodule

// File: tb/tb_seg7_temp_display.sv
// Bench for seg7_temp_display: directed scenarios plus random traffic against a frame-position model.
module tb_seg7_temp_display;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    logic        clk = 1'b0;
    logic        Rst, En, Load;
    logic [15:0] temp;
    logic [6:0]  Seg;
    logic        Dp;
    logic [3:0]  An;

    int vectors = 0;
    int miscompares = 0;

    // Model: position within the 4-slot frame plus the two stored temperatures.
    int          pos = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp = '0;

    seg7_temp_display #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk (clk),
        .Rst (Rst),
        .En  (En),
        .Load(Load),
        .temp(temp),
        .Seg (Seg),
        .Dp  (Dp),
        .An  (An)
    );

    always #5 clk = ~clk;

    function automatic void model_expect(input logic rst, input logic en,
                                         output logic [6:0] s, output logic d, output logic [3:0] a);
        int idx, cnt;
        s = 7'h7F; d = 1'b1; a = 4'hF;
        idx = pos / DIV;
        cnt = pos % DIV;
        if (!rst && en && cnt >= BLANK) begin
            a[idx] = 1'b0;
            case (idx)
                0: s = DEC[m_disp[3:0]];
                1: begin s = DEC[m_disp[7:4]]; d = 1'b0; end
                2: s = (LZB && m_disp[11:8] == 4'd0) ? 7'h7F : DEC[m_disp[11:8]];
                default: s = (m_disp[15:12] != 4'd0) ? 7'h3F : 7'h7F;
            endcase
        end
    endfunction

    function automatic void model_update(input logic rst, input logic en, input logic load,
                                         input logic [15:0] t);
        if (rst) begin
            pos = 0; m_shadow = '0; m_disp = '0;
        end else begin
            if (en) begin
                if (pos == FRAME - 1) begin
                    m_disp = load ? t : m_shadow;
                    pos = 0;
                end else begin
                    pos++;
                end
            end else begin
                pos = 0;
            end
            if (load) m_shadow = t;
        end
    endfunction

    task automatic step(input logic rst, input logic en, input logic load, input logic [15:0] t,
                        input string tag);
        logic [6:0] es; logic ed; logic [3:0] ea;
        @(negedge clk);
        Rst = rst; En = en; Load = load; temp = t;
        model_expect(rst, en, es, ed, ea);
        model_update(rst, en, load, t);
        @(posedge clk);
        #1;
        vectors++;
        assert ({Seg, Dp, An} === {es, ed, ea}) else begin
            miscompares++;
            $error("FAIL %s: Seg/Dp/An got %h/%b/%h want %h/%b/%h", tag, Seg, Dp, An, es, ed, ea);
        end
    endtask

    task automatic check_lit(input string tag, input logic [6:0] s, input logic d, input logic [3:0] a);
        vectors++;
        assert ({Seg, Dp, An} === {s, d, a}) else begin
            miscompares++;
            $error("FAIL %s: Seg/Dp/An got %h/%b/%h want %h/%b/%h", tag, Seg, Dp, An, s, d, a);
        end
    endtask

    // Scan with En=1 until the model sits at (idx,cnt), then clock once so outputs show that point.
    task automatic run_to(input int idx, input int cnt, input string tag);
        int guard = 0;
        while (pos != idx * DIV + cnt && guard < 4 * FRAME) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, tag);
            guard++;
        end
        if (guard >= 4 * FRAME) begin
            miscompares++;
            $error("FAIL %s: scan position %0d never reached target %0d", tag, pos, idx * DIV + cnt);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, tag);
    endtask

    initial begin
        Rst = 1'b1; En = 1'b0; Load = 1'b0; temp = '0;

        step(1'b1, 1'b0, 1'b0, 16'h0, "reset");
        check_lit("reset_lit", 7'h7F, 1'b1, 4'hF);
        for (int i = 0; i < 5000; i++) step(1'b0, 1'b0, 1'b0, 16'($urandom), "en_off");
        check_lit("en_off_lit", 7'h7F, 1'b1, 4'hF);

        step(1'b0, 1'b1, 1'b1, 16'h0235, "load_0235");
        run_to(3, DIV - 1, "frame1");
        run_to(0, 0, "blank0");
        check_lit("blank_slot0", 7'h7F, 1'b1, 4'hF);
        run_to(0, BLANK, "t0235");
        check_lit("0235_tenths", 7'h12, 1'b1, 4'hE);
        run_to(1, BLANK, "t0235");
        check_lit("0235_units", 7'h30, 1'b0, 4'hD);
        run_to(2, BLANK, "t0235");
        check_lit("0235_tens", 7'h24, 1'b1, 4'hB);
        run_to(3, BLANK, "t0235");
        check_lit("0235_sign", 7'h7F, 1'b1, 4'h7);

        step(1'b0, 1'b1, 1'b1, 16'h1050, "load_1050");
        run_to(3, DIV - 1, "t1050");
        run_to(2, BLANK, "t1050");
        check_lit("1050_tens", LZB ? 7'h7F : 7'h40, 1'b1, 4'hB);
        run_to(3, BLANK, "t1050");
        check_lit("1050_sign", 7'h3F, 1'b1, 4'h7);

        run_to(3, DIV - 1, "t0999");
        run_to(1, 3, "t0999");
        step(1'b0, 1'b1, 1'b1, 16'h0999, "load_midframe");
        run_to(2, BLANK, "t0999");
        check_lit("midframe_old_tens", LZB ? 7'h7F : 7'h40, 1'b1, 4'hB);
        run_to(3, BLANK, "t0999");
        check_lit("midframe_old_sign", 7'h3F, 1'b1, 4'h7);
        run_to(3, DIV - 1, "t0999");
        run_to(0, BLANK, "t0999");
        check_lit("next_frame_new", 7'h10, 1'b1, 4'hE);

        run_to(3, DIV - 2, "wrapload");
        step(1'b0, 1'b1, 1'b1, 16'h0412, "load_on_wrap");
        run_to(0, BLANK, "wrapload");
        check_lit("wrap_load_same_frame", 7'h24, 1'b1, 4'hE);

        step(1'b0, 1'b1, 1'b1, 16'h00A0, "load_00A0");
        run_to(3, DIV - 1, "t00A0");
        run_to(1, BLANK, "t00A0");
        check_lit("00A0_units_E", 7'h06, 1'b0, 4'hD);

        run_to(2, 4, "pre_rst");
        step(1'b1, 1'b1, 1'b0, 16'h0, "rst_mid");
        check_lit("rst_mid_dark", 7'h7F, 1'b1, 4'hF);
        step(1'b0, 1'b1, 1'b0, 16'h0, "post_rst0");
        step(1'b0, 1'b1, 1'b0, 16'h0, "post_rst1");
        check_lit("post_rst_blank", 7'h7F, 1'b1, 4'hF);
        step(1'b0, 1'b1, 1'b0, 16'h0, "post_rst2");
        check_lit("post_rst_slot0", 7'h40, 1'b1, 4'hE);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 100) != 0, ($urandom % 12) == 0,
                 16'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
